// File: rtl/mem_port_arbiter.sv
// Two-master (fetch/data) arbiter onto one single-outstanding memory port.
// Round-robin on ties, per-transaction timeout, all outputs registered.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        sel,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_t;

  localparam logic [9:0] LP_TIMEOUT = 10'(TIMEOUT);

  state_t      r_state, w_state;
  logic        r_last_d, w_last_d;
  logic [9:0]  r_cnt, w_cnt;
  logic        r_i_gnt, w_i_gnt, r_d_gnt, w_d_gnt;
  logic        r_i_rvalid, w_i_rvalid, r_d_rvalid, w_d_rvalid;
  logic        r_i_err, w_i_err, r_d_err, w_d_err;
  logic [31:0] r_i_rdata, w_i_rdata, r_d_rdata, w_d_rdata;
  logic        r_sel, w_sel, r_m_req, w_m_req, r_m_we, w_m_we;
  logic [31:0] r_m_addr, w_m_addr, r_m_wdata, w_m_wdata;
  logic        w_cmpl_hold;
  logic [31:0] w_rd_val;

  // A completion cycle blocks arbitration so grants are at least 3 cycles apart.
  assign w_cmpl_hold = r_i_rvalid | r_d_rvalid;
  assign w_rd_val    = (m_ack && !r_m_we) ? m_rdata : 32'd0;

  // Next-state and next-output logic.
  always_comb begin
    w_state    = r_state;
    w_last_d   = r_last_d;
    w_cnt      = r_cnt;
    w_i_gnt    = 1'b0;
    w_d_gnt    = 1'b0;
    w_i_rvalid = 1'b0;
    w_d_rvalid = 1'b0;
    w_i_err    = 1'b0;
    w_d_err    = 1'b0;
    w_i_rdata  = r_i_rdata;
    w_d_rdata  = r_d_rdata;
    w_sel      = r_sel;
    w_m_req    = r_m_req;
    w_m_we     = r_m_we;
    w_m_addr   = r_m_addr;
    w_m_wdata  = r_m_wdata;
    case (r_state)
      ST_IDLE: begin
        if (w_cmpl_hold) begin
          w_state = ST_IDLE;
        end else if (i_req && (!d_req || r_last_d)) begin
          w_state   = ST_BUSY_I;
          w_last_d  = 1'b0;
          w_cnt     = 10'd0;
          w_i_gnt   = 1'b1;
          w_sel     = 1'b0;
          w_m_req   = 1'b1;
          w_m_we    = 1'b0;
          w_m_addr  = i_addr;
          w_m_wdata = 32'd0;
        end else if (d_req) begin
          w_state   = ST_BUSY_D;
          w_last_d  = 1'b1;
          w_cnt     = 10'd0;
          w_d_gnt   = 1'b1;
          w_sel     = 1'b1;
          w_m_req   = 1'b1;
          w_m_we    = d_we;
          w_m_addr  = d_addr;
          w_m_wdata = d_wdata;
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        // An ack in the timeout cycle takes precedence over the error.
        if (m_ack || (r_cnt == LP_TIMEOUT)) begin
          w_state = ST_IDLE;
          w_m_req = 1'b0;
          if (r_state == ST_BUSY_D) begin
            w_d_rvalid = 1'b1;
            w_d_err    = ~m_ack;
            w_d_rdata  = w_rd_val;
          end else begin
            w_i_rvalid = 1'b1;
            w_i_err    = ~m_ack;
            w_i_rdata  = w_rd_val;
          end
        end else begin
          w_cnt = r_cnt + 10'd1;
        end
      end
      default: begin
        w_state = ST_IDLE;
        w_m_req = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_last_d   <= 1'b1;
      r_cnt      <= 10'd0;
      r_i_gnt    <= 1'b0;
      r_d_gnt    <= 1'b0;
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_err    <= 1'b0;
      r_d_err    <= 1'b0;
      r_i_rdata  <= 32'd0;
      r_d_rdata  <= 32'd0;
      r_sel      <= 1'b0;
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= 32'd0;
      r_m_wdata  <= 32'd0;
    end else begin
      r_state    <= w_state;
      r_last_d   <= w_last_d;
      r_cnt      <= w_cnt;
      r_i_gnt    <= w_i_gnt;
      r_d_gnt    <= w_d_gnt;
      r_i_rvalid <= w_i_rvalid;
      r_d_rvalid <= w_d_rvalid;
      r_i_err    <= w_i_err;
      r_d_err    <= w_d_err;
      r_i_rdata  <= w_i_rdata;
      r_d_rdata  <= w_d_rdata;
      r_sel      <= w_sel;
      r_m_req    <= w_m_req;
      r_m_we     <= w_m_we;
      r_m_addr   <= w_m_addr;
      r_m_wdata  <= w_m_wdata;
    end
  end

  assign i_gnt    = r_i_gnt;
  assign d_gnt    = r_d_gnt;
  assign i_rvalid = r_i_rvalid;
  assign d_rvalid = r_d_rvalid;
  assign i_err    = r_i_err;
  assign d_err    = r_d_err;
  assign i_rdata  = r_i_rdata;
  assign d_rdata  = r_d_rdata;
  assign sel      = r_sel;
  assign m_req    = r_m_req;
  assign m_we     = r_m_we;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (TIMEOUT=4): completions are queued
// when stimulus is driven and checked by a monitor when rvalid appears.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_gnt, i_rvalid, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        sel, m_req, m_we, m_ack;
  logic [31:0] m_addr, m_wdata, m_rdata;

  typedef struct packed {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .sel(sel), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic is_d, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.is_d  = is_d;
    e.rdata = rdata;
    e.err   = err;
    sb_q.push_back(e);
  endtask

  task automatic do_ack(input logic [31:0] data);
    m_ack   = 1'b1;
    m_rdata = data;
    tick();
    m_ack   = 1'b0;
    m_rdata = 32'd0;
  endtask

  task automatic wait_grant(input logic want_d);
    int n = 0;
    tick();
    while (!(i_gnt || d_gnt) && n < 10) begin
      tick();
      n++;
    end
    chk_eq("gnt_i", {31'd0, i_gnt}, {31'd0, ~want_d});
    chk_eq("gnt_d", {31'd0, d_gnt}, {31'd0, want_d});
    chk_eq("gnt_sel", {31'd0, sel}, {31'd0, want_d});
    chk_eq("gnt_mreq", {31'd0, m_req}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk_eq("drain", sb_q.size(), 32'd0);
  endtask

  // Completion monitor: pops the scoreboard on every rvalid pulse.
  always @(negedge clk) begin
    if (i_rvalid || d_rvalid) begin
      if (sb_q.size() == 0) begin
        chk_eq("spurious_rvalid", {30'd0, d_rvalid, i_rvalid}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk_eq("cmpl_side", {30'd0, d_rvalid, i_rvalid}, e.is_d ? 32'd2 : 32'd1);
        chk_eq("cmpl_rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
        chk_eq("cmpl_err", {31'd0, e.is_d ? d_err : i_err}, {31'd0, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 1'b0; i_req = 1'b0; i_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'd0; d_wdata = 32'd0; m_ack = 1'b0; m_rdata = 32'd0;
    tick(); tick();
    chk_eq("rst_mreq", {31'd0, m_req}, 32'd0);
    chk_eq("rst_sel", {31'd0, sel}, 32'd0);
    chk_eq("rst_outs", {27'd0, i_gnt, d_gnt, i_rvalid, d_rvalid, m_we}, 32'd0);
    chk_eq("rst_rdata", i_rdata | d_rdata | m_addr | m_wdata, 32'd0);
    rst_n = 1'b1;

    // Basic fetch, ack two cycles after m_req rises.
    i_req = 1'b1; i_addr = 32'h100;
    push_exp(1'b0, 32'h13, 1'b0);
    tick();
    chk_eq("f_gnt", {31'd0, i_gnt}, 32'd1);
    chk_eq("f_addr", m_addr, 32'h100);
    chk_eq("f_sel", {31'd0, sel}, 32'd0);
    chk_eq("f_we", {31'd0, m_we}, 32'd0);
    i_req = 1'b0;
    tick();
    chk_eq("f_gnt_pulse", {31'd0, i_gnt}, 32'd0);
    tick();
    chk_eq("f_mreq_held", {31'd0, m_req}, 32'd1);
    do_ack(32'h13);
    chk_eq("f_mreq_drop", {31'd0, m_req}, 32'd0);
    drain();

    // Tie after reset: fetch first, data 3 cycles later, ack in grant cycle.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    tick();
    chk_eq("tie_i_gnt", {31'd0, i_gnt}, 32'd1);
    chk_eq("tie_d_gnt0", {31'd0, d_gnt}, 32'd0);
    i_req = 1'b0;
    push_exp(1'b0, 32'hAAAA0001, 1'b0);
    do_ack(32'hAAAA0001);
    chk_eq("tie_d_gnt1", {31'd0, d_gnt}, 32'd0);
    tick();
    chk_eq("tie_d_gnt2", {31'd0, d_gnt}, 32'd0);
    tick();
    chk_eq("tie_d_gnt3", {31'd0, d_gnt}, 32'd1);
    chk_eq("tie_d_addr", m_addr, 32'h40);
    d_req = 1'b0;
    push_exp(1'b1, 32'h5555, 1'b0);
    do_ack(32'h5555);
    i_req = 1'b1; i_addr = 32'h204; d_req = 1'b1; d_addr = 32'h44;
    wait_grant(1'b0);
    i_req = 1'b0;
    push_exp(1'b0, 32'h11, 1'b0);
    do_ack(32'h11);
    wait_grant(1'b1);
    d_req = 1'b0;
    push_exp(1'b1, 32'h5556, 1'b0);
    do_ack(32'h5556);
    drain();

    // Timeout: m_req high TIMEOUT+1 cycles then error completion.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
    push_exp(1'b1, 32'd0, 1'b1);
    wait_grant(1'b1);
    d_req = 1'b0;
    cnt = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (m_req) cnt++;
      else break;
    end
    chk_eq("to_mreq_cycles", cnt, 32'd5);
    drain();

    // Ack arriving in the timeout cycle wins.
    d_req = 1'b1; d_addr = 32'h3004;
    wait_grant(1'b1);
    d_req = 1'b0;
    tick(); tick(); tick(); tick();
    chk_eq("to_ack_mreq", {31'd0, m_req}, 32'd1);
    push_exp(1'b1, 32'h77, 1'b0);
    do_ack(32'h77);
    drain();

    // Data write: rdata reported as zero regardless of m_rdata.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
    wait_grant(1'b1);
    chk_eq("w_we", {31'd0, m_we}, 32'd1);
    chk_eq("w_wdata", m_wdata, 32'hDEADBEEF);
    chk_eq("w_addr", m_addr, 32'h2000);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    chk_eq("w_wdata_held", m_wdata, 32'hDEADBEEF);
    push_exp(1'b1, 32'd0, 1'b0);
    do_ack(32'h12345678);
    drain();

    // Reset during BUSY_I aborts silently; a late ack is ignored.
    i_req = 1'b1; i_addr = 32'h400;
    wait_grant(1'b0);
    i_req = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk_eq("abort_mreq", {31'd0, m_req}, 32'd0);
    rst_n = 1'b1;
    do_ack(32'hBAD0BAD0);
    tick(); tick();
    chk_eq("abort_idle_mreq", {31'd0, m_req}, 32'd0);
    i_req = 1'b1; i_addr = 32'h500;
    wait_grant(1'b0);
    chk_eq("fresh_addr", m_addr, 32'h500);
    i_req = 1'b0;
    push_exp(1'b0, 32'h99, 1'b0);
    tick();
    do_ack(32'h99);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 255, max cycles BUSY waits for m_ack before error completion (1..1023).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 i_req  input  1  instruction-fetch request; held with i_addr until i_gnt.
REQ-005 i_addr  input  32  fetch address.
REQ-006 i_gnt  output  1  one-cycle pulse: fetch request accepted.
REQ-007 i_rvalid  output  1  one-cycle pulse: fetch complete; i_rdata/i_err valid.
REQ-008 i_rdata  output  32  fetch read data.
REQ-009 i_err  output  1  fetch completed by timeout.
REQ-010 d_req  input  1  data request; held with d_we/d_addr/d_wdata until d_gnt.
REQ-011 d_we  input  1  1 = write, 0 = read.
REQ-012 d_addr  input  32  data address.
REQ-013 d_wdata  input  32  write data.
REQ-014 d_gnt, d_rvalid, d_err  output  1 each  data-side equivalents of REQ-006/007/009.
REQ-015 d_rdata  output  32  data read data.
REQ-016 sel  output  1  shared-port 2:1 mux select; 0 = fetch, 1 = data.
REQ-017 m_req  output  1  memory request, held until m_ack or timeout.
REQ-018 m_we  output  1  memory write enable.
REQ-019 m_addr, m_wdata  output  32 each  memory address / write data.
REQ-020 m_ack  input  1  memory completion, single-cycle pulse.
REQ-021 m_rdata  input  32  memory read data, valid with m_ack.

Function
REQ-022 FSM states IDLE, BUSY_I, BUSY_D; one outstanding transaction max.
REQ-023 All outputs registered; none combinationally dependent on inputs.
REQ-024 IDLE, one request: next cycle enter BUSY_x, pulse x_gnt, m_req=1, sel set, addr/we/wdata latched (fetch: m_we=0, m_wdata=0).
REQ-025 IDLE, both requests: round-robin via last_owner; owner other than last_owner wins; loser keeps requesting, granted after winner completes.
REQ-026 last_owner updates at grant.
REQ-027 BUSY_x: m_req, m_we, m_addr, m_wdata, sel stable until exit.
REQ-028 m_ack in BUSY_x: next cycle m_req=0, x_rvalid=1, x_err=0, x_rdata=m_rdata (read) or 0 (write), state IDLE.
REQ-029 m_ack in same cycle as m_req rises (grant cycle): completes per REQ-028.
REQ-030 Wait counter clears on grant, increments each BUSY cycle without m_ack; at count==TIMEOUT with no m_ack, next cycle x_rvalid=1, x_err=1, x_rdata=0, m_req=0, IDLE.
REQ-031 m_ack in timeout cycle: ack wins, x_err=0.
REQ-032 m_ack in IDLE: ignored, no rvalid.
REQ-033 Completion cycle is in IDLE; new grant earliest next cycle, so minimum 3 cycles between grants.
REQ-034 x_rdata holds last value between completions; gnt/rvalid/err are single-cycle pulses.
REQ-035 Requests arriving during BUSY are neither granted nor dropped; evaluated on return to IDLE.

Reset
REQ-036 rst_n=0 at edge: state IDLE, last_owner=D (fetch wins first tie), counter 0, all outputs 0 incl. sel and rdata.
REQ-037 Reset mid-transaction: m_req drops at that edge; no rvalid/err for aborted transaction; late m_ack ignored.

Verification
REQ-038 i_req=1, i_addr=0x100 after reset, m_ack 2 cycles after m_req, m_rdata=0x00000013 -> i_gnt next cycle, m_addr=0x100, sel=0, then i_rvalid=1, i_rdata=0x13, i_err=0.
REQ-039 i_req and d_req both 1 in IDLE after reset -> fetch granted first; d_gnt 3 cycles after i_gnt given immediate m_ack; next tie -> fetch again (last_owner=D).
REQ-040 d_req, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF -> m_we=1, m_wdata=0xDEADBEEF, sel=1; on m_ack d_rvalid=1, d_rdata=0.
REQ-041 TIMEOUT=4, d read, no m_ack -> m_req high 5 cycles, then d_rvalid=1, d_err=1, d_rdata=0; repeat with m_ack in timeout cycle -> d_err=0.
REQ-042 rst_n low during BUSY_I -> m_req=0 next edge, no i_rvalid ever; later m_ack ignored; fresh request completes normally.
